pc_ir_stage: RTL and testbench

//  Fetch-side register stage of the multi-cycle MIPS32 datapath: holds PC, instruction register (IR)
//  and memory data register (MDR). Consumes PCWr/PCWrCond/PCSrc/IRWr from controlUnit plus ALU

---
 rtl/pc_ir_stage.sv | 94 +++++++++
 tb/tb_pc_ir_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_stage.sv
// Fetch-side register stage of the multi-cycle MIPS32 datapath: PC, IR and MDR,
// local branch-condition evaluation, sticky PC misalignment flag and halt latch.
module pc_ir_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          HALT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic        PCWrCond,
    input  logic [1:0]  PCSrc,
    input  logic        IRWr,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        zero,
    input  logic        alu_neg,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [31:0] imm_sext,
    output logic [31:0] mdr,
    output logic        halted,
    output logic        misalign
);

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic        taken;
    logic        pc_we;
    logic [31:0] pc_next;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign func     = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            OP_BGTZ: taken = !zero && !alu_neg;
            OP_BLEZ: taken = zero || alu_neg;
            default: taken = 1'b0;
        endcase
    end

    // pc already holds PC+4 when a jump executes, so its top nibble is the right one
    always_comb begin
        pc_next = '0;
        case (PCSrc)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = alu_out;
            2'b10:   pc_next = {pc[31:28], instr[25:0], 2'b00};
            default: pc_next = '0;
        endcase
    end

    assign pc_we = !halted && (PCSrc != 2'b11) && (PCWr || (PCWrCond && taken));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr    <= '0;
            mdr      <= '0;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            mdr <= mem_rdata;
            if (IRWr && !halted)
                instr <= mem_rdata;
            if (pc_we)
                pc <= {pc_next[31:2], 2'b00};
            if (pc_we && (pc_next[1:0] != 2'b00))
                misalign <= 1'b1;
            if (HALT_EN && (opcode == OP_HALT))
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_ir_stage.sv
// Directed bench for pc_ir_stage: table of per-cycle control vectors with expected
// PC/IR/flags, plus hand sequences for field decode, halt and asynchronous reset.
module tb_pc_ir_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWr, PCWrCond, IRWr, zero, alu_neg;
    logic [1:0]  PCSrc;
    logic [31:0] alu_result, alu_out, mem_rdata;
    logic [31:0] pc, instr, imm_sext, mdr;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic        halted, misalign;

    int checks = 0;
    int errors = 0;

    pc_ir_stage dut (
        .clk(clk), .rst(rst), .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc),
        .IRWr(IRWr), .alu_result(alu_result), .alu_out(alu_out), .zero(zero),
        .alu_neg(alu_neg), .mem_rdata(mem_rdata), .pc(pc), .instr(instr),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm_sext(imm_sext), .mdr(mdr), .halted(halted), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcwr, cond;
        logic [1:0]  src;
        logic        irwr;
        logic [31:0] ar, ao;
        logic        z, n;
        logic [31:0] mem;
        logic [31:0] epc, einstr;
        logic        emis;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(logic pcwr, logic cond, logic [1:0] src, logic irwr,
                                logic [31:0] ar, logic [31:0] ao, logic z, logic n,
                                logic [31:0] mem, logic [31:0] epc, logic [31:0] einstr,
                                logic emis);
        vec_t v;
        v.pcwr = pcwr; v.cond = cond; v.src = src; v.irwr = irwr;
        v.ar = ar; v.ao = ao; v.z = z; v.n = n; v.mem = mem;
        v.epc = epc; v.einstr = einstr; v.emis = emis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        PCWr = 0; PCWrCond = 0; PCSrc = 2'b11; IRWr = 0;
        alu_result = '0; alu_out = '0; zero = 0; alu_neg = 0; mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rows: pcwr cond src irwr alu_result alu_out zero neg mem | pc instr misalign
        vt[0]  = mk(1,0,2'b00,1,32'h4,0,0,0,32'h012A_4020, 32'h4, 32'h012A_4020,0);
        vt[1]  = mk(1,0,2'b00,1,32'h8,0,0,0,32'h1000_0004, 32'h8, 32'h1000_0004,0);
        vt[2]  = mk(0,1,2'b01,0,0,32'h100,0,0,0, 32'h8,   32'h1000_0004,0);
        vt[3]  = mk(0,1,2'b01,0,0,32'h100,1,0,0, 32'h100, 32'h1000_0004,0);
        vt[4]  = mk(0,0,2'b11,1,0,0,0,0,32'h1400_0000, 32'h100, 32'h1400_0000,0);
        vt[5]  = mk(0,1,2'b01,0,0,32'h200,1,0,0, 32'h100, 32'h1400_0000,0);
        vt[6]  = mk(0,1,2'b01,0,0,32'h200,0,0,0, 32'h200, 32'h1400_0000,0);
        vt[7]  = mk(0,0,2'b11,1,0,0,0,0,32'h1C00_0000, 32'h200, 32'h1C00_0000,0);
        vt[8]  = mk(0,1,2'b01,0,0,32'h300,0,0,0, 32'h300, 32'h1C00_0000,0);
        vt[9]  = mk(0,1,2'b01,0,0,32'h340,0,1,0, 32'h300, 32'h1C00_0000,0);
        vt[10] = mk(0,0,2'b11,1,0,0,0,0,32'h1800_0000, 32'h300, 32'h1800_0000,0);
        vt[11] = mk(0,1,2'b01,0,0,32'h400,0,1,0, 32'h400, 32'h1800_0000,0);
        vt[12] = mk(0,1,2'b01,0,0,32'h440,0,0,0, 32'h400, 32'h1800_0000,0);
        vt[13] = mk(0,1,2'b01,0,0,32'h480,1,0,0, 32'h480, 32'h1800_0000,0);
        vt[14] = mk(1,1,2'b01,0,0,32'h500,0,0,0, 32'h500, 32'h1800_0000,0);
        vt[15] = mk(1,0,2'b11,0,32'h603,0,0,0,0, 32'h500, 32'h1800_0000,0);
        vt[16] = mk(0,0,2'b11,1,0,0,0,0,32'h012A_4020, 32'h500, 32'h012A_4020,0);
        vt[17] = mk(0,1,2'b01,0,0,32'h700,1,0,0, 32'h500, 32'h012A_4020,0);
        vt[18] = mk(1,0,2'b00,0,32'h1000_0008,0,0,0,0, 32'h1000_0008, 32'h012A_4020,0);
        vt[19] = mk(0,0,2'b11,1,0,0,0,0,32'h0800_0040, 32'h1000_0008, 32'h0800_0040,0);
        vt[20] = mk(1,0,2'b10,0,0,0,0,0,0, 32'h1000_0100, 32'h0800_0040,0);
        vt[21] = mk(1,0,2'b00,0,32'h6,0,0,0,0, 32'h4, 32'h0800_0040,1);
        vt[22] = mk(1,0,2'b00,0,32'h8,0,0,0,0, 32'h8, 32'h0800_0040,1);
        vt[23] = mk(1,0,2'b00,0,32'hFFFF_FFFC,0,0,0,0, 32'hFFFF_FFFC, 32'h0800_0040,1);
        vt[24] = mk(1,0,2'b00,0,32'h0,0,0,0,0, 32'h0, 32'h0800_0040,1);

        idle();
        rst = 1;
        #12;
        chk("reset_pc", pc, 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_mdr", mdr, 32'h0);
        chk("reset_flags", {30'b0, halted, misalign}, 32'h0);
        chk("reset_imm", imm_sext, 32'h0);
        @(negedge clk); rst = 0;

        for (int i = 0; i < 25; i++) begin
            logic [31:0] m;
            m = vt[i].irwr ? vt[i].mem : (32'hD000_0000 + i);
            @(negedge clk);
            PCWr = vt[i].pcwr; PCWrCond = vt[i].cond; PCSrc = vt[i].src; IRWr = vt[i].irwr;
            alu_result = vt[i].ar; alu_out = vt[i].ao; zero = vt[i].z; alu_neg = vt[i].n;
            mem_rdata = m;
            step();
            chk($sformatf("v%0d_pc", i), pc, vt[i].epc);
            chk($sformatf("v%0d_instr", i), instr, vt[i].einstr);
            chk($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vt[i].emis});
            chk($sformatf("v%0d_halt", i), {31'b0, halted}, 32'h0);
            chk($sformatf("v%0d_mdr", i), mdr, m);
            if (i == 0) begin
                chk("fetch_opcode", {26'b0, opcode}, 32'h0);
                chk("fetch_func", {26'b0, func}, 32'h20);
                chk("fetch_rs", {27'b0, rs}, 32'd9);
                chk("fetch_rt", {27'b0, rt}, 32'd10);
                chk("fetch_rd", {27'b0, rd}, 32'd8);
            end
        end

        // sign-extended immediate and remaining fields
        @(negedge clk); idle(); IRWr = 1; mem_rdata = 32'h8D09_FFF0;
        step();
        chk("lw_opcode", {26'b0, opcode}, 32'h23);
        chk("lw_rs_rt", {22'b0, rs, rt}, {22'b0, 5'd8, 5'd9});
        chk("lw_rd_shamt", {22'b0, rd, shamt}, {22'b0, 5'd31, 5'd31});
        chk("lw_func", {26'b0, func}, 32'h30);
        chk("lw_imm", imm_sext, 32'hFFFF_FFF0);

        // halt: load halt opcode, one idle edge, then controls must be ignored
        @(negedge clk); idle(); IRWr = 1; PCWr = 1; PCSrc = 2'b00;
        alu_result = 32'h20; mem_rdata = 32'hFC00_0000;
        step();
        chk("halt_load_pc", pc, 32'h20);
        chk("halt_load_flag", {31'b0, halted}, 32'h0);
        @(negedge clk); idle();
        step();
        chk("halt_set", {31'b0, halted}, 32'h1);
        @(negedge clk); idle(); IRWr = 1; PCWr = 1; PCSrc = 2'b00;
        alu_result = 32'h80; mem_rdata = 32'h1234_5678;
        step();
        chk("halt_pc_frozen", pc, 32'h20);
        chk("halt_instr_frozen", instr, 32'hFC00_0000);
        chk("halt_mdr_runs", mdr, 32'h1234_5678);
        chk("halt_sticky", {31'b0, halted}, 32'h1);
        chk("halt_mis_kept", {31'b0, misalign}, 32'h1);
        @(negedge clk); idle(); rst = 1;
        #1;
        chk("halt_rst_clear", {31'b0, halted}, 32'h0);
        chk("halt_rst_mis", {31'b0, misalign}, 32'h0);
        @(negedge clk); rst = 0;

        // asynchronous reset in the middle of a cycle
        @(negedge clk); idle(); IRWr = 1; PCWr = 1; PCSrc = 2'b00;
        alu_result = 32'h40; mem_rdata = 32'h012A_4020;
        step();
        chk("pre_rst_pc", pc, 32'h40);
        @(negedge clk); idle(); IRWr = 1; PCWr = 1; PCSrc = 2'b00;
        alu_result = 32'h44; mem_rdata = 32'h0123_4567;
        #2 rst = 1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_halt", {31'b0, halted}, 32'h0);
        step();
        chk("rst_held_pc", pc, 32'h0);
        @(negedge clk); rst = 0; idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
